// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin scheduler that shares one UART transmitter between NREQ byte producers.
// Latency: a request that is valid in IDLE gets req_ready in the same cycle and tx_enable in the next cycle.
// Backpressure: a grant is made only in IDLE with tx_busy low. Other requests wait, and the arbiter does not hold them.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   req_valid/req_data     per-requester byte offer (requester i at req_data[8i+7:8i])
//   req_ready              one-hot, 1-cycle capture pulse
//   tx_byte/tx_enable      byte and 1-cycle launch pulse to the transmitter
//   tx_busy                transmitter frame in progress
//   grant_id               index of last/current granted requester
//   ctrl_busy              high whenever the scheduler is not idle
//   start_err              sticky: the transmitter never started a launched frame
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = 16,
    parameter int START_TO = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_enable,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              ctrl_busy,
    output logic              start_err
);

    localparam int MAXC     = (START_TO > GAP_CYC) ? START_TO : GAP_CYC;
    localparam int CW       = $clog2(MAXC + 1);
    // The timeout fires on the cycle in which the counter would step to START_TO-1.
    // This makes start_err visible exactly START_TO cycles after the launch pulse.
    localparam int TO_LAST  = (START_TO >= 2) ? START_TO - 2 : 0;
    localparam int GAP_LOAD = (GAP_CYC >= 1) ? GAP_CYC - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [2:0]      rr_ptr;
    logic            rst_q;      // blocks grants on the cycle right after reset
    logic            found;
    logic [2:0]      gsel;
    int              idx;
    logic            grant_fire;
    logic            err_set;

    // Round-robin search: the first valid requester at or above rr_ptr, with wrap-around.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gsel  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        grant_fire = 1'b0;
        err_set    = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!rst && !rst_q && !tx_busy && found) begin
                    grant_fire = 1'b1;
                    req_ready  = NREQ'(1) << gsel;
                    state_nxt  = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt >= CW'(TO_LAST)) begin
                    // The transmitter never started. Drop the byte and still enforce the gap.
                    err_set = 1'b1;
                    if (GAP_CYC == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = CW'(GAP_LOAD);
                        state_nxt = GAP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYC == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = CW'(GAP_LOAD);
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rst_q     <= 1'b1;
            cnt       <= '0;
            rr_ptr    <= '0;
            tx_byte   <= '0;
            grant_id  <= '0;
            start_err <= 1'b0;
        end else begin
            state <= state_nxt;
            rst_q <= 1'b0;
            cnt   <= cnt_nxt;
            if (err_set) begin
                start_err <= 1'b1;
            end
            if (grant_fire) begin
                // tx_byte stays unchanged until the next grant, so it is stable for the whole frame.
                tx_byte  <= req_data[8*int'(gsel) +: 8];
                grant_id <= gsel;
                rr_ptr   <= 3'((int'(gsel) + 1) % NREQ);
            end
        end
    end

    assign tx_enable = (state == LAUNCH) && !rst;
    assign ctrl_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_byte;
    logic        tx_enable;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        ctrl_busy;
    logic        start_err;

    // second instance with no inter-frame gap
    logic [3:0]  rv1;
    logic [31:0] rd1;
    logic [3:0]  rr1;
    logic [7:0]  tb1;
    logic        te1;
    logic        busy1;
    logic [2:0]  gid1;
    logic        cb1;
    logic        se1;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYC(16), .START_TO(1024)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_byte(tx_byte), .tx_enable(tx_enable),
        .tx_busy(tx_busy), .grant_id(grant_id), .ctrl_busy(ctrl_busy),
        .start_err(start_err)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYC(0), .START_TO(1024)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_data(rd1),
        .req_ready(rr1), .tx_byte(tb1), .tx_enable(te1),
        .tx_busy(busy1), .grant_id(gid1), .ctrl_busy(cb1),
        .start_err(se1)
    );

    // Transmitter model: busy for 100 cycles after each launch, or never busy when disabled.
    localparam int FRAME = 100;
    logic model_en;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        if (rst)                        busy_cnt <= 0;
        else if (model_en && tx_enable) busy_cnt <= FRAME;
        else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Event log, sampled on the falling edge.
    int         cyc = 0;
    int         tx_cyc[$];
    logic [7:0] tx_dat[$];
    int         gnt[$];
    int         err_cyc = -1;
    logic       err_prev = 1'b0;
    always @(negedge clk) begin
        if (tx_enable) begin
            tx_cyc.push_back(cyc);
            tx_dat.push_back(tx_byte);
        end
        for (int i = 0; i < 4; i++)
            if (req_ready[i] && req_valid[i]) gnt.push_back(i);
        if (start_err && !err_prev) err_cyc = cyc;
        err_prev = start_err;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        for (int n = 0; n < bound && ctrl_busy; n++) step(1);
        chk("idle_reached", ctrl_busy, 1'b0);
    endtask

    int   base;
    int   gb;
    logic [3:0] acc;

    initial begin
        rst = 1'b1; req_valid = 4'h0; req_data = 32'h13121110; model_en = 1'b1;
        rv1 = 4'h0; rd1 = 32'h0; busy1 = 1'b0;
        step(2);
        // reset state
        chk("rst_ready",  req_ready, 4'h0);
        chk("rst_enable", tx_enable, 1'b0);
        chk("rst_byte",   tx_byte,   8'h00);
        chk("rst_gid",    grant_id,  3'd0);
        chk("rst_busy",   ctrl_busy, 1'b0);
        chk("rst_err",    start_err, 1'b0);

        // single request: the cycle right after reset may not grant
        rst = 1'b0; req_valid = 4'b0001; req_data = 32'h131211A5;
        #1;
        chk("post_rst_no_grant", req_ready, 4'h0);
        step(1); #1;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_no_enable_yet", tx_enable, 1'b0);
        step(1); #1;
        chk("t1_enable", tx_enable, 1'b1);
        chk("t1_byte",   tx_byte,   8'hA5);
        chk("t1_gid",    grant_id,  3'd0);
        chk("t1_ready_drop", req_ready, 4'h0);
        req_valid = 4'h0;
        step(50);
        chk("t1_byte_hold", tx_byte, 8'hA5);
        chk("t1_txbusy",    tx_busy, 1'b1);
        wait_idle(300);

        // fairness: all four valid, pointer restarted at 0
        rst = 1'b1; step(1); rst = 1'b0;
        req_data = 32'h13121110; req_valid = 4'hF;
        base = tx_cyc.size();
        for (int n = 0; n < 1000 && tx_cyc.size() < base + 5; n++) step(1);
        req_valid = 4'h0;
        chk("t2_count", tx_cyc.size() >= base + 5, 1'b1);
        for (int i = 0; i < 5; i++)
            chk("t2_byte", tx_dat[base+i], 8'h10 + 8'(i % 4));
        for (int i = 1; i < 5; i++)
            chk("t2_spacing", tx_cyc[base+i] - tx_cyc[base+i-1], 119);
        wait_idle(400);

        // pointer at 2 after a grant to 1; requesters 1 and 3 give 1,3,1
        gb = gnt.size();
        req_valid = 4'b0010;
        for (int n = 0; n < 50 && gnt.size() < gb + 1; n++) step(1);
        req_valid = 4'b1010;
        for (int n = 0; n < 600 && gnt.size() < gb + 3; n++) step(1);
        req_valid = 4'h0;
        chk("t3_g0", gnt[gb],   1);
        chk("t3_g1", gnt[gb+1], 3);
        chk("t3_g2", gnt[gb+2], 1);
        wait_idle(400);

        // start timeout: the transmitter never goes busy
        model_en = 1'b0;
        base = tx_cyc.size(); gb = gnt.size();
        req_valid = 4'b0101;
        for (int n = 0; n < 1200 && tx_cyc.size() < base + 2; n++) step(1);
        req_valid = 4'h0;
        chk("t4_err_delay",  err_cyc - tx_cyc[base], 1024);
        chk("t4_relaunch",   tx_cyc[base+1] - tx_cyc[base], 1041);
        chk("t4_g0",         gnt[gb],   2);
        chk("t4_g1",         gnt[gb+1], 0);
        chk("t4_byte0",      tx_dat[base],   8'h12);
        chk("t4_byte1",      tx_dat[base+1], 8'h10);
        chk("t4_err_sticky", start_err, 1'b1);
        wait_idle(1200);
        chk("t4_err_still", start_err, 1'b1);
        model_en = 1'b1;

        // reset in the middle of a frame (WAIT_DONE)
        gb = gnt.size();
        req_valid = 4'b0001;
        for (int n = 0; n < 50 && gnt.size() < gb + 1; n++) step(1);
        req_valid = 4'h0;
        step(10);
        chk("t5_busy_before", ctrl_busy, 1'b1);
        chk("t5_txbusy",      tx_busy,   1'b1);
        rst = 1'b1; step(1); rst = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("t5_ready", req_ready, 4'h0);
        chk("t5_enable", tx_enable, 1'b0);
        chk("t5_byte",  tx_byte,   8'h00);
        chk("t5_gid",   grant_id,  3'd0);
        chk("t5_cbusy", ctrl_busy, 1'b0);
        chk("t5_err",   start_err, 1'b0);
        step(1); #1;
        chk("t5_grant0", req_ready, 4'b0001);
        step(1); #1;
        req_valid = 4'h0;
        chk("t5_gid_after", grant_id, 3'd0);
        chk("t5_byte_after", tx_byte, 8'h10);
        wait_idle(400);

        // zero-gap build: no grant while tx_busy is high in IDLE
        busy1 = 1'b1; rv1 = 4'b0100; rd1 = 32'h00C30000;
        acc = 4'h0;
        for (int n = 0; n < 5; n++) begin
            #1; acc = acc | rr1;
            step(1);
        end
        chk("t6_no_grant_busy", acc, 4'h0);
        busy1 = 1'b0;
        #1;
        chk("t6_grant", rr1, 4'b0100);
        step(1); #1;
        chk("t6_enable", te1, 1'b1);
        chk("t6_byte",   tb1, 8'hC3);
        chk("t6_gid",    gid1, 3'd2);
        rv1 = 4'h0; busy1 = 1'b1;
        step(2); #1;
        chk("t6_wait_done", cb1, 1'b1);
        busy1 = 1'b0;
        step(1); #1;
        chk("t6_direct_idle", cb1, 1'b0);
        chk("t6_no_err", se1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
